// File: rtl/gate_n_pkg.sv
// gate_n_pkg: function-select encodings and sweep FSM states
// shared by gate_n_eval and gate_n_sweep.
package gate_n_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/gate_n_eval.sv
// gate_n_eval: combinational N-input reduce gate; reserved modes
// yield 0.
module gate_n_eval
    import gate_n_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [2:0]      i_mode,
    input  logic [N_IN-1:0] i_data,
    output logic            o_result
);

    always_comb begin
        o_result = 1'b0;
        case (i_mode)
            MODE_AND:  o_result = &i_data;
            MODE_OR:   o_result = |i_data;
            MODE_NAND: o_result = ~&i_data;
            MODE_NOR:  o_result = ~|i_data;
            MODE_XOR:  o_result = ^i_data;
            MODE_XNOR: o_result = ~^i_data;
            default:   o_result = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_n_sweep.sv
// gate_n_sweep: configurable N-input gate with valid/ready input and a
// truth-table sweep engine. GATE_N_SWEEP_ABORT_EN adds i_abort.
module gate_n_sweep
    import gate_n_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int DWELL = 1000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [2:0]      i_mode,
    input  logic [N_IN-1:0] i_din,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_start,
`ifdef GATE_N_SWEEP_ABORT_EN
    input  logic            i_abort,
`endif
    output logic            o_y1,
    output logic            o_y2,
    output logic            o_valid,
    output logic            o_busy,
    output logic            o_done,
    output logic [N_IN-1:0] o_pattern,
    output logic [N_IN:0]   o_ones_cnt
);

    localparam int DW = $clog2(DWELL + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N_IN-1:0] PAT_LAST = '1;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_mode;
    logic [N_IN-1:0] r_pattern;
    logic [DW-1:0]   r_dwell;
    logic [N_IN:0]   r_ones;
    logic            r_y1;
    logic            r_y2;
    logic            r_valid;

    logic            w_sweep;
    logic            w_start;
    logic            w_accept;
    logic            w_dwell_last;
    logic            w_pat_last;
    logic            w_abort;
    logic [2:0]      w_eval_mode;
    logic [N_IN-1:0] w_eval_data;
    logic            w_result;

`ifdef GATE_N_SWEEP_ABORT_EN
    assign w_abort = i_abort & w_sweep;
`else
    assign w_abort = 1'b0;
`endif

    assign w_sweep      = (r_state == ST_SWEEP);
    assign o_ready      = (r_state == ST_IDLE) & ~i_start;
    assign w_start      = (r_state == ST_IDLE) & i_start;
    assign w_accept     = i_valid & o_ready;
    assign w_dwell_last = (r_dwell == DWELL_LAST);
    assign w_pat_last   = (r_pattern == PAT_LAST);

    // One evaluator shared by both paths: sweep uses the latched mode.
    assign w_eval_mode = w_sweep ? r_mode : i_mode;
    assign w_eval_data = w_sweep ? r_pattern : i_din;

    gate_n_eval #(.N_IN(N_IN)) u_eval (
        .i_mode   (w_eval_mode),
        .i_data   (w_eval_data),
        .o_result (w_result)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_SWEEP;
            end
            ST_SWEEP: begin
                o_busy = 1'b1;
                if (w_abort)
                    w_next = ST_IDLE;
                else if (w_dwell_last && w_pat_last)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode    <= '0;
            r_pattern <= '0;
            r_dwell   <= '0;
            r_ones    <= '0;
            r_y1      <= 1'b0;
            r_y2      <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_start) begin
                r_mode    <= i_mode;
                r_pattern <= '0;
                r_dwell   <= '0;
                r_ones    <= '0;
            end else if (w_sweep) begin
                r_y1 <= w_result;
                r_y2 <= ~w_result;
                if (w_dwell_last && w_result)
                    r_ones <= r_ones + 1'b1;
                // An abort still counts the cycle it lands on.
                if (!w_abort) begin
                    if (w_dwell_last) begin
                        r_dwell <= '0;
                        if (!w_pat_last)
                            r_pattern <= r_pattern + 1'b1;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
            end else if (w_accept) begin
                r_y1 <= w_result;
                r_y2 <= ~w_result;
            end
        end
    end

    assign o_y1       = r_y1;
    assign o_y2       = r_y2;
    assign o_valid    = r_valid;
    assign o_pattern  = r_pattern;
    assign o_ones_cnt = r_ones;

endmodule

// File: tb/tb_gate_n_sweep.sv
// tb_gate_n_sweep: randomized self-checking bench for gate_n_sweep
// (N_IN=4, DWELL=2) against a truth-table reference model.
module tb_gate_n_sweep;

    localparam int N     = 4;
    localparam int DWELL = 2;
    localparam int NP    = 1 << N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   i_mode = '0;
    logic [N-1:0] i_din = '0;
    logic         i_valid = 1'b0;
    logic         i_start = 1'b0;
    logic         i_abort = 1'b0;
    logic         o_ready;
    logic         o_y1;
    logic         o_y2;
    logic         o_valid;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_pattern;
    logic [N:0]   o_ones_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gate_n_sweep #(.N_IN(N), .DWELL(DWELL)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_mode     (i_mode),
        .i_din      (i_din),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_start    (i_start),
`ifdef GATE_N_SWEEP_ABORT_EN
        .i_abort    (i_abort),
`endif
        .o_y1       (o_y1),
        .o_y2       (o_y2),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_pattern  (o_pattern),
        .o_ones_cnt (o_ones_cnt)
    );

    // Function defined by how many inputs are high.
    function automatic logic ref_gate(input logic [2:0] m,
                                      input logic [N-1:0] d);
        int k;
        k = $countones(d);
        case (m)
            3'd0:    return k == N;
            3'd1:    return k > 0;
            3'd2:    return k != N;
            3'd3:    return k == 0;
            3'd4:    return (k % 2) == 1;
            3'd5:    return (k % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int exp_ones(input logic [2:0] m);
        int s;
        s = 0;
        for (int p = 0; p < NP; p++)
            s += int'(ref_gate(m, N'(p)));
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has already driven i_start; runs until back in IDLE.
    task automatic sweep_body(input logic [2:0] lm, input logic [2:0] mid,
                              output int nb, output int nd,
                              output int perr, output bit tmo);
        nb = 0;
        nd = 0;
        perr = 0;
        tmo = 1'b1;
        for (int c = 0; c < 4 * NP * DWELL + 8; c++) begin
            tick();
            i_start = 1'b0;
            if (o_valid !== 1'b0) perr++;
            if (o_busy) begin
                if (o_pattern !== N'(nb / DWELL)) perr++;
                if (nb > 0) begin
                    if (o_y1 !== ref_gate(lm, N'((nb - 1) / DWELL))) perr++;
                    if (o_y2 !== ~o_y1) perr++;
                end
                nb++;
            end else if (o_done) begin
                nd++;
            end else begin
                tmo = 1'b0;
                break;
            end
            i_mode  = mid;
            i_valid = 1'($urandom);
            i_din   = N'($urandom);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        total++;
        if ({o_y1, o_y2, o_valid, o_busy, o_done, o_pattern, o_ones_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outs got=%b exp=0",
                     {o_y1, o_y2, o_valid, o_busy, o_done, o_pattern, o_ones_cnt});
        end
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", o_ready);
        end
        i_mode = 3'd1;
        i_din = 4'b0001;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({o_y1, o_y2, o_valid, o_busy, o_done, o_pattern, o_ones_cnt} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b exp=0",
                     {o_y1, o_y2, o_valid, o_busy, o_done, o_pattern, o_ones_cnt});
        end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_normal();
        logic [N-1:0] d;
        logic [2:0]   m;
        logic         v;
        logic         ey;
        int           err;
        i_mode = 3'd0;
        i_din = 4'b1111;
        i_valid = 1'b1;
        tick();
        total++;
        if ({o_valid, o_y1, o_y2} !== 3'b110) begin
            bad++;
            $display("FAIL norm_and got=%b exp=110", {o_valid, o_y1, o_y2});
        end
        i_mode = 3'd4;
        i_din = 4'b0111;
        tick();
        total++;
        if ({o_valid, o_y1, o_y2} !== 3'b110) begin
            bad++;
            $display("FAIL norm_xor got=%b exp=110", {o_valid, o_y1, o_y2});
        end
        ey = 1'b1;
        err = 0;
        for (int i = 0; i < 60; i++) begin
            d = N'($urandom);
            m = 3'($urandom_range(0, 7));
            v = 1'($urandom);
            i_din = d;
            i_mode = m;
            i_valid = v;
            tick();
            if (v) ey = ref_gate(m, d);
            if ({o_valid, o_y1, o_y2} !== {v, ey, ~ey}) begin
                err++;
                $display("FAIL norm_rand i=%0d got=%b exp=%b",
                         i, {o_valid, o_y1, o_y2}, {v, ey, ~ey});
            end
        end
        i_valid = 1'b0;
        total++;
        if (err != 0) bad++;
    endtask

    task automatic test_sweep_modes();
        int  nb, nd, perr;
        bit  tmo;
        for (int m = 0; m < 8; m++) begin
            i_mode = 3'(m);
            i_start = 1'b1;
            sweep_body(3'(m), 3'($urandom_range(0, 7)), nb, nd, perr, tmo);
            total++;
            if (tmo || nb != NP * DWELL || nd != 1) begin
                bad++;
                $display("FAIL sweep_len m=%0d busy=%0d done=%0d tmo=%0d exp=%0d/1",
                         m, nb, nd, tmo, NP * DWELL);
            end
            total++;
            if (o_ones_cnt !== (N + 1)'(exp_ones(3'(m)))) begin
                bad++;
                $display("FAIL sweep_ones m=%0d got=%0d exp=%0d",
                         m, o_ones_cnt, exp_ones(3'(m)));
            end
            total++;
            if (perr != 0 || o_pattern !== N'(NP - 1)) begin
                bad++;
                $display("FAIL sweep_trace m=%0d errs=%0d pat=%0d exp=0/%0d",
                         m, perr, o_pattern, NP - 1);
            end
        end
    endtask

    task automatic test_collision();
        int nb, nd, perr;
        bit tmo;
        i_mode = 3'd0;
        i_din = 4'b1111;
        i_valid = 1'b1;
        i_start = 1'b1;
        #1;
        total++;
        if (o_ready !== 1'b0) begin
            bad++;
            $display("FAIL coll_ready got=%b exp=0", o_ready);
        end
        sweep_body(3'd0, 3'd1, nb, nd, perr, tmo);
        total++;
        if (tmo || nb != NP * DWELL || nd != 1 || perr != 0) begin
            bad++;
            $display("FAIL coll_sweep busy=%0d done=%0d errs=%0d tmo=%0d",
                     nb, nd, perr, tmo);
        end
        total++;
        if (o_ones_cnt !== (N + 1)'(1)) begin
            bad++;
            $display("FAIL coll_ones got=%0d exp=1", o_ones_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int nb, nd, perr, dn;
        bit tmo;
        i_mode = 3'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({o_busy, o_done, o_pattern, o_ones_cnt, o_y1, o_y2} !== '0) begin
            bad++;
            $display("FAIL midrst_outs got=%b exp=0",
                     {o_busy, o_done, o_pattern, o_ones_cnt, o_y1, o_y2});
        end
        tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_done || o_busy) dn++;
        end
        total++;
        if (dn != 0) begin
            bad++;
            $display("FAIL midrst_quiet got=%0d exp=0", dn);
        end
        i_mode = 3'd4;
        i_start = 1'b1;
        sweep_body(3'd4, 3'd0, nb, nd, perr, tmo);
        total++;
        if (tmo || nb != NP * DWELL || nd != 1 || perr != 0
            || o_ones_cnt !== (N + 1)'(exp_ones(3'd4))) begin
            bad++;
            $display("FAIL midrst_fresh busy=%0d done=%0d errs=%0d ones=%0d exp=%0d",
                     nb, nd, perr, o_ones_cnt, exp_ones(3'd4));
        end
    endtask

`ifdef GATE_N_SWEEP_ABORT_EN
    task automatic test_abort();
        int dn;
        i_mode = 3'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        total++;
        if ({o_busy, o_done} !== 2'b00 || o_pattern !== N'(4)
            || o_ones_cnt !== (N + 1)'(4)) begin
            bad++;
            $display("FAIL abort got busy=%b done=%b pat=%0d ones=%0d exp=0/0/4/4",
                     o_busy, o_done, o_pattern, o_ones_cnt);
        end
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_done) dn++;
        end
        total++;
        if (dn != 0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle done=%0d ready=%b exp=0/1", dn, o_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_sweep_modes();
        test_collision();
        test_reset_mid();
`ifdef GATE_N_SWEEP_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_n_sweep.md
Name: gate_n_sweep

Overview:
Parametrised N-input configurable logic gate with registered outputs and a valid/ready input handshake. It is the next generation of the 4-input gate block.
- Adds run-time function select.
- Adds a built-in exhaustive truth-table sweep engine, which walks all 2^N_IN input patterns, holds each for DWELL cycles, and counts patterns where o_y1=1.
- Used standalone in the lab top for self-test, and as a gate primitive in later designs.

Parameters:
N_IN, 4, number of gate inputs (2..8)
DWELL, 1000, cycles each sweep pattern is held (>=1)

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_mode  in  3  function select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved
i_din  in  N_IN  operand bits (normal mode)
i_valid  in  1  operand valid
o_ready  out  1  block accepts operand this cycle
i_start  in  1  request sweep (sampled in IDLE only)
o_y1  out  1  registered gate result
o_y2  out  1  registered complement of o_y1
o_valid  out  1  o_y1/o_y2 hold a normal-mode result
o_busy  out  1  sweep in progress
o_done  out  1  one-cycle pulse at sweep end
o_pattern  out  N_IN  current sweep pattern
o_ones_cnt  out  N_IN+1  patterns with result 1 in last sweep

Behaviour:
- Clock and reset: single clock i_clk. i_rst is asynchronous and active-high.
- Reset: all outputs are 0 (o_y1=0, o_y2=0, o_valid=0, o_busy=0, o_done=0, o_pattern=0, o_ones_cnt=0). FSM goes to IDLE, and the dwell counter clears. o_ready reads 1 once reset deasserts and i_start=0.
- Evaluation: reduce operation over the N_IN bits per mode. Reserved modes give result 0. o_y2 = ~o_y1 always, including after reset? No: at reset both are 0. After the first registered update, o_y2 = ~o_y1.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - o_ready = ~i_start (combinational).
  - If i_valid & o_ready: o_y1/o_y2 update from i_din next cycle, and o_valid=1 for exactly that cycle (latency 1). Otherwise o_valid=0 and o_y1/o_y2 hold.
  - If i_start: mode is latched, o_pattern=0, dwell counter=0, o_ones_cnt=0, o_busy=1 next cycle. State goes to SWEEP.
  - i_start and i_valid in the same cycle: start wins, and the operand is not accepted.
- SWEEP:
  - o_ready=0, i_valid is ignored, and o_valid=0.
  - o_y1/o_y2 register the gate result for o_pattern every cycle, using the latched mode. A change to i_mode mid-sweep has no effect.
  - The dwell counter counts 0..DWELL-1.
  - On the dwell last cycle, if the current pattern's result is 1, o_ones_cnt increments (evaluated combinationally, not from the lagged o_y1).
  - If o_pattern = 2^N_IN-1 at the dwell last cycle, state goes to DONE. Otherwise o_pattern increments and the dwell counter clears.
  - SWEEP lasts exactly 2^N_IN*DWELL cycles.
- DONE:
  - Lasts one cycle with o_done=1 and o_busy=0. State then goes to IDLE.
  - i_start is ignored in DONE.
  - o_ones_cnt and o_pattern hold until the next sweep start.
- Width: o_ones_cnt is N_IN+1 bits and must represent 2^N_IN without wrap. The dwell counter is $clog2(DWELL+1) bits.
- Reset mid-sweep: immediate return to IDLE with all outputs at their reset values. No o_done pulse.

Optional Feature:
Macro GATE_N_SWEEP_ABORT_EN.
- Defined: adds input port i_abort (1 bit).
  - i_abort=1 in SWEEP goes to IDLE next cycle, with o_busy=0 and no o_done.
  - o_ones_cnt and o_pattern hold their partial values.
  - i_abort is ignored in IDLE and DONE.
- Undefined: no port, and a sweep always runs to completion.

Decomposition:
- Package gate_n_pkg: mode encodings (MODE_AND..MODE_XNOR) and FSM state enum/localparams.
- Sub-module gate_n_eval: purely combinational, parameter N_IN, inputs mode and data, output result. It is instantiated once and shared by the normal path and the sweep path through a mux on the data and mode inputs.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle -> all outputs 0 immediately. o_ready=1 after release.
- Normal mode, N_IN=4, DWELL=2, mode=0: i_din=4'b1111 with i_valid -> next cycle o_valid=1, o_y1=1, o_y2=0. Then i_din=4'b0111, mode=4 -> o_y1=1.
- Sweep per mode, N_IN=4, DWELL=2:
  - Pulse i_start -> o_busy high for 32 cycles, then o_done pulse.
  - Required o_ones_cnt: AND 1, OR 15, NAND 15, NOR 1, XOR 8, XNOR 8, mode 6 -> 0.
- Handshake collisions:
  - i_start and i_valid same cycle -> o_ready=0 that cycle, no o_valid, sweep starts.
  - i_valid during SWEEP -> o_valid stays 0.
  - i_mode changed mid-sweep (AND->OR) -> final o_ones_cnt=1.
- Reset at sweep cycle 10 -> o_busy=0, o_pattern=0, o_ones_cnt=0, no o_done. A fresh i_start then completes normally.
- With GATE_N_SWEEP_ABORT_EN: i_abort at sweep cycle 9, mode=OR -> IDLE next cycle, no o_done, o_pattern=4, o_ones_cnt=4.
